dm_cache_fsm: RTL

Controller for the direct-mapped, 8-line instruction cache; sits directly upstream of dm_cache_tag and dm_cache_data and drives their request/write ports.
Accepts CPU fetch requests and checks the tag on a tag-memory read. On a hit it returns the addressed word. On a miss it fetches the whole line from memory, then writes the tag and data lines.
After reset it also runs an invalidate sweep, because tag memory has no reset.

---
 rtl/dm_cache_fsm_pkg.sv | 36 +++
 rtl/dm_cache_fsm_if.sv | 25 ++
 rtl/dm_cache_fsm.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dm_cache_fsm_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
// Covers the controller, tag memory and data memory.
package icache_def;

   localparam int ADDR_W   = 16;
   localparam int INDEX_W  = 3;
   localparam int OFFSET_W = 2;
   localparam int WORD_W   = 16;
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINE_W   = WORD_W << OFFSET_W;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } cache_tag_type;

   typedef struct packed {
      logic [INDEX_W-1:0] index;
      logic               we;
   } cache_req_type;

   typedef logic [LINE_W-1:0] cache_data_type;

   typedef enum logic [1:0] {FLUSH, IDLE, COMPARE, ALLOCATE} cache_state_type;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [INDEX_W-1:0]  index;
      logic [OFFSET_W-1:0] offset;
   } cache_addr_type;

   function automatic cache_addr_type addr_fields(input logic [ADDR_W-1:0] addr);
      return cache_addr_type'(addr);
   endfunction

endpackage

// File: rtl/dm_cache_fsm_if.sv
// CPU fetch and memory fill buses of the instruction cache controller.
// master: CPU/memory side, slave: cache controller side.
interface dm_cache_fsm_if;
   import icache_def::*;

   logic                cpu_req_valid;
   logic [ADDR_W-1:0]   cpu_req_addr;
   logic                cpu_res_ready;
   logic [WORD_W-1:0]   cpu_res_data;
   logic                mem_req_valid;
   logic [ADDR_W-1:0]   mem_req_addr;
   logic                mem_res_ready;
   cache_data_type      mem_res_data;

   modport master (
      output cpu_req_valid, cpu_req_addr, mem_res_ready, mem_res_data,
      input  cpu_res_ready, cpu_res_data, mem_req_valid, mem_req_addr
   );

   modport slave (
      input  cpu_req_valid, cpu_req_addr, mem_res_ready, mem_res_data,
      output cpu_res_ready, cpu_res_data, mem_req_valid, mem_req_addr
   );

endinterface

// File: rtl/dm_cache_fsm.sv
// Controller for the 8-line direct-mapped instruction cache: invalidate sweep,
// tag compare with word return, and whole-line fill from memory on a miss.
module dm_cache_fsm
   import icache_def::*;
(
   input  logic           clk,
   input  logic           rst,
   dm_cache_fsm_if.slave  bus,
   input  logic           inv_req,
   output logic           busy,
   output cache_req_type  tag_req,
   output cache_tag_type  tag_write,
   input  cache_tag_type  tag_read,
   output cache_req_type  data_req,
   output cache_data_type data_write,
   input  cache_data_type data_read
);

   cache_state_type     state_q, state_d;
   logic [INDEX_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                res_ready_q, res_ready_d;
   logic [WORD_W-1:0]   res_data_q, res_data_d;
   logic                mreq_valid_q, mreq_valid_d;
   logic [ADDR_W-1:0]   mreq_addr_q, mreq_addr_d;

   cache_addr_type      f;
   logic                hit;

   assign f   = addr_fields(addr_q);
   assign hit = tag_read.valid && (tag_read.tag == f.tag);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FLUSH;
         cnt_q        <= '0;
         addr_q       <= '0;
         res_ready_q  <= 1'b0;
         res_data_q   <= '0;
         mreq_valid_q <= 1'b0;
         mreq_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         res_ready_q  <= res_ready_d;
         res_data_q   <= res_data_d;
         mreq_valid_q <= mreq_valid_d;
         mreq_addr_q  <= mreq_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      res_ready_d  = 1'b0;
      res_data_d   = res_data_q;
      mreq_valid_d = mreq_valid_q;
      mreq_addr_d  = mreq_addr_q;
      unique case (state_q)
         FLUSH: begin
            cnt_d = cnt_q + INDEX_W'(1);
            if (cnt_q == '1) state_d = IDLE;
         end
         IDLE: begin
            if (inv_req) begin
               cnt_d   = '0;
               state_d = FLUSH;
            // The CPU still holds valid in the cycle it sees the response; don't re-accept it.
            end else if (bus.cpu_req_valid && !res_ready_q) begin
               addr_d  = bus.cpu_req_addr;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (hit) begin
               res_ready_d = 1'b1;
               res_data_d  = data_read[int'(f.offset) * WORD_W +: WORD_W];
               state_d     = IDLE;
            end else begin
               mreq_valid_d = 1'b1;
               mreq_addr_d  = {f.tag, f.index, {OFFSET_W{1'b0}}};
               state_d      = ALLOCATE;
            end
         end
         ALLOCATE: begin
            if (bus.mem_res_ready) begin
               mreq_valid_d = 1'b0;
               state_d      = COMPARE;
            end
         end
         default: state_d = FLUSH;
      endcase
   end

   always_comb begin
      busy       = (state_q != IDLE);
      tag_req    = '{index: f.index, we: 1'b0};
      data_req   = '{index: f.index, we: 1'b0};
      tag_write  = '0;
      data_write = bus.mem_res_data;
      unique case (state_q)
         FLUSH: begin
            tag_req.index = cnt_q;
            tag_req.we    = 1'b1;
         end
         ALLOCATE: begin
            // A response arriving in the reset cycle must not land in the arrays.
            if (bus.mem_res_ready && !rst) begin
               tag_req.we   = 1'b1;
               tag_write    = '{valid: 1'b1, tag: f.tag};
               data_req.we  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.cpu_res_ready = res_ready_q;
   assign bus.cpu_res_data  = res_data_q;
   assign bus.mem_req_valid = mreq_valid_q;
   assign bus.mem_req_addr  = mreq_addr_q;

endmodule
